// File: rtl/bram_arb_pkg.sv
// Shared types for the BRAM port arbiter: requester ids, FSM states and
// the read-tag bundle carried through the return pipeline.
package bram_arb_pkg;

    localparam logic [1:0] SRC_BOOT = 2'd0;
    localparam logic [1:0] SRC_I    = 2'd1;
    localparam logic [1:0] SRC_D    = 2'd2;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FLUSH = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    typedef enum logic {
        RR_I = 1'b0,
        RR_D = 1'b1
    } rr_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] src;
    } tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-latency tag shift register: tracks which requester owns each
// in-flight read so the returning data can be steered.
module rd_tag_pipe
    import bram_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [1:0] src,
    output tag_t       head,
    output logic       empty
);

    tag_t [DEPTH-1:0] stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage <= {stage[DEPTH-2:0], tag_t'{valid: push, src: src}};
        end
    end

    always_comb begin
        empty = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            if (stage[k].valid) empty = 1'b0;
        end
    end

    assign head = stage[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Single BRAM port shared by bootloader, instruction fetch and data access;
// boot-only until boot_ready, then round-robin between fetch and data.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        boot_ready,
    input  logic        b_en,
    input  logic [3:0]  b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    input  logic        d_req,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] rdata,
    output logic        viol,
    output logic [31:0] BRAM_ADDR,
    output logic [31:0] BRAM_WRDATA,
    output logic [3:0]  BRAM_WE,
    output logic        BRAM_EN,
    input  logic [31:0] BRAM_RDDATA
);

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    state_t     state;
    rr_t        rr_ptr;
    logic       run_ok;
    logic       boot_fwd;
    logic       rd_push;
    logic [1:0] push_src;
    tag_t       head;
    logic       empty;

    // A falling boot_ready stops new grants while the pipe drains.
    assign run_ok   = (state == S_RUN) && boot_ready;
    assign i_gnt    = run_ok && i_req && (!d_req || rr_ptr == RR_I);
    assign d_gnt    = run_ok && d_req && (!i_req || rr_ptr == RR_D);
    assign boot_fwd = b_en && (state == S_BOOT || state == S_FLUSH);

    always_comb begin
        rd_push  = 1'b0;
        push_src = SRC_BOOT;
        unique case (1'b1)
            boot_fwd: rd_push = (b_we == 4'b0);
            i_gnt: begin
                rd_push  = 1'b1;
                push_src = SRC_I;
            end
            d_gnt: begin
                rd_push  = (d_we == 4'b0);
                push_src = SRC_D;
            end
            default: ;
        endcase
    end

    rd_tag_pipe #(.DEPTH(RD_LATENCY + 1)) u_tags (
        .clk   (CLK),
        .rst_n (RSTN),
        .push  (rd_push),
        .src   (push_src),
        .head  (head),
        .empty (empty)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state  <= S_BOOT;
            rr_ptr <= RR_D;
            viol   <= 1'b0;
        end else begin
            unique case (state)
                S_BOOT:  if (boot_ready) state <= S_FLUSH;
                S_FLUSH: state <= S_RUN;
                S_RUN:   if (!boot_ready && empty) state <= S_BOOT;
                default: state <= S_BOOT;
            endcase
            if (run_ok && i_req && d_req)
                rr_ptr <= (rr_ptr == RR_D) ? RR_I : RR_D;
            if ((state == S_RUN && b_en) ||
                (state == S_BOOT && (i_req || d_req)))
                viol <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            BRAM_EN     <= 1'b0;
            BRAM_WE     <= 4'b0;
            BRAM_ADDR   <= 32'b0;
            BRAM_WRDATA <= 32'b0;
        end else begin
            BRAM_EN <= boot_fwd || i_gnt || d_gnt;
            BRAM_WE <= 4'b0;
            unique case (1'b1)
                boot_fwd: begin
                    BRAM_WE     <= b_we;
                    BRAM_ADDR   <= b_addr & WORD_MASK;
                    BRAM_WRDATA <= b_wdata;
                end
                i_gnt: BRAM_ADDR <= i_addr & WORD_MASK;
                d_gnt: begin
                    BRAM_WE     <= d_we;
                    BRAM_ADDR   <= d_addr & WORD_MASK;
                    BRAM_WRDATA <= d_wdata;
                end
                default: ;
            endcase
        end
    end

    // Boot reads occupy the pipe but their data is dropped.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            rdata    <= 32'b0;
        end else begin
            i_rvalid <= head.valid && (head.src == SRC_I);
            d_rvalid <= head.valid && (head.src == SRC_D);
            if (head.valid && head.src != SRC_BOOT)
                rdata <= BRAM_RDDATA;
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a BRAM model and a
// scoreboard-driven read-return monitor.
module tb_bram_port_arbiter;

    localparam int LAT = 1;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        boot_ready = 1'b0;
    logic        b_en = 1'b0;
    logic [3:0]  b_we = 4'b0;
    logic [31:0] b_addr = 32'b0;
    logic [31:0] b_wdata = 32'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'b0;
    logic        i_gnt;
    logic        i_rvalid;
    logic        d_req = 1'b0;
    logic [3:0]  d_we = 4'b0;
    logic [31:0] d_addr = 32'b0;
    logic [31:0] d_wdata = 32'b0;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] rdata;
    logic        viol;
    logic [31:0] BRAM_ADDR;
    logic [31:0] BRAM_WRDATA;
    logic [3:0]  BRAM_WE;
    logic        BRAM_EN;
    logic [31:0] BRAM_RDDATA;

    bram_port_arbiter #(.RD_LATENCY(LAT)) dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .boot_ready  (boot_ready),
        .b_en        (b_en),
        .b_we        (b_we),
        .b_addr      (b_addr),
        .b_wdata     (b_wdata),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_gnt       (i_gnt),
        .i_rvalid    (i_rvalid),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_gnt       (d_gnt),
        .d_rvalid    (d_rvalid),
        .rdata       (rdata),
        .viol        (viol),
        .BRAM_ADDR   (BRAM_ADDR),
        .BRAM_WRDATA (BRAM_WRDATA),
        .BRAM_WE     (BRAM_WE),
        .BRAM_EN     (BRAM_EN),
        .BRAM_RDDATA (BRAM_RDDATA)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // BRAM model: one-cycle registered read, byte-lane writes.
    logic [31:0] mem [256];
    logic [31:0] rd_q = 32'b0;
    bit          loaded = 1'b0;
    assign BRAM_RDDATA = rd_q;

    always @(posedge CLK) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE0000 | 32'(i * 4);
            mem[4] <= 32'hDEADBEEF;
            loaded <= 1'b1;
        end else if (BRAM_EN) begin
            rd_q <= mem[BRAM_ADDR[9:2]];
            for (int b = 0; b < 4; b++)
                if (BRAM_WE[b]) mem[BRAM_ADDR[9:2]][8*b +: 8] <= BRAM_WRDATA[8*b +: 8];
        end
    end

    int n_run = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        int          at;
    } exp_t;
    exp_t sb[$];

    task automatic expect_rd(bit is_d, logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        e.at   = cyc + 2 + LAT;
        sb.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (RSTN && (i_rvalid || d_rvalid)) begin
            if (i_rvalid && d_rvalid) chk("both_rvalid", 32'd1, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rvalid_is_d", {31'b0, d_rvalid}, {31'b0, e.is_d});
                chk("rdata", rdata, e.data);
                chk("rvalid_cycle", cyc, e.at);
            end
        end
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic mid;
        @(negedge CLK);
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_addr"}, BRAM_ADDR, 32'd0);
        chk({tag, "_wrdata"}, BRAM_WRDATA, 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_ctl"}, {25'b0, BRAM_EN, BRAM_WE, i_gnt, d_gnt, i_rvalid, d_rvalid}, 32'd0);
        chk({tag, "_viol"}, {31'b0, viol}, 32'd0);
    endtask

    initial begin
        bit exp_d;
        logic [31:0] ia, da;

        step; step;
        chk_all_zero("reset");
        step; RSTN = 1'b1;

        // Boot write then boot read, then idle hold
        step;
        b_en = 1'b1; b_we = 4'b1000; b_addr = 32'h7; b_wdata = 32'hAB000000;
        step;
        b_we = 4'b0000; b_addr = 32'h8;
        mid;
        chk("boot_wr_en", {31'b0, BRAM_EN}, 32'd1);
        chk("boot_wr_we", {28'b0, BRAM_WE}, 32'h8);
        chk("boot_wr_addr", BRAM_ADDR, 32'h4);
        chk("boot_wr_data", BRAM_WRDATA, 32'hAB000000);
        step;
        b_en = 1'b0;
        mid;
        chk("boot_rd_en_we", {27'b0, BRAM_EN, BRAM_WE}, 32'h10);
        chk("boot_rd_addr", BRAM_ADDR, 32'h8);
        step;
        mid;
        chk("idle_en_we", {27'b0, BRAM_EN, BRAM_WE}, 32'h0);
        chk("idle_addr_hold", BRAM_ADDR, 32'h8);
        chk("idle_wrdata_hold", BRAM_WRDATA, 32'hAB000000);
        chk("boot_no_viol", {31'b0, viol}, 32'd0);

        // Handover with fetch already requesting
        step;
        boot_ready = 1'b1; i_req = 1'b1; i_addr = 32'h4;
        mid;
        chk("handover_gnt_t0", {31'b0, i_gnt}, 32'd0);
        step;
        mid;
        chk("handover_gnt_t1", {31'b0, i_gnt}, 32'd0);
        chk("handover_viol", {31'b0, viol}, 32'd1);
        step;
        mid;
        chk("handover_gnt_t2", {31'b0, i_gnt}, 32'd1);
        expect_rd(1'b0, 32'hABDE0004);
        step;
        i_req = 1'b0;
        repeat (5) step;

        RSTN = 1'b0;
        #1;
        chk("viol_cleared", {31'b0, viol}, 32'd0);
        step; RSTN = 1'b1;
        step; step; step;

        // Contention: d,i,d,i
        for (int k = 0; k < 4; k++) begin
            step;
            ia = 32'h20 + 32'(4 * (k / 2));
            da = 32'h30 + 32'(4 * ((k + 1) / 2));
            i_req = 1'b1; i_addr = ia;
            d_req = 1'b1; d_addr = da; d_we = 4'b0;
            exp_d = (k % 2 == 0);
            mid;
            chk($sformatf("arb_i_gnt_%0d", k), {31'b0, i_gnt}, {31'b0, !exp_d});
            chk($sformatf("arb_d_gnt_%0d", k), {31'b0, d_gnt}, {31'b0, exp_d});
            expect_rd(exp_d, 32'hC0DE0000 | (exp_d ? da : ia));
        end
        step;
        i_req = 1'b0;

        // Data read, write, read-back
        d_req = 1'b1; d_addr = 32'h10; d_we = 4'b0;
        mid;
        chk("d_rd_gnt", {31'b0, d_gnt}, 32'd1);
        expect_rd(1'b1, 32'hDEADBEEF);
        step;
        d_addr = 32'h40; d_we = 4'b0011; d_wdata = 32'h11223344;
        mid;
        chk("d_wr_gnt", {31'b0, d_gnt}, 32'd1);
        step;
        d_we = 4'b0;
        mid;
        chk("d_rb_gnt", {31'b0, d_gnt}, 32'd1);
        chk("d_wr_port_we", {27'b0, BRAM_EN, BRAM_WE}, 32'h13);
        chk("d_wr_port_addr", BRAM_ADDR, 32'h40);
        chk("d_wr_port_data", BRAM_WRDATA, 32'h11223344);
        expect_rd(1'b1, 32'hC0DE3344);
        step;
        d_req = 1'b0;
        repeat (5) step;
        mid;
        chk("run_no_viol", {31'b0, viol}, 32'd0);

        // Boot strobe in run mode is a violation and is not forwarded
        step;
        b_en = 1'b1; b_we = 4'b1111; b_addr = 32'h80;
        step;
        b_en = 1'b0;
        mid;
        chk("viol_set", {31'b0, viol}, 32'd1);
        chk("viol_no_en", {31'b0, BRAM_EN}, 32'd0);
        repeat (3) step;
        mid;
        chk("viol_sticky", {31'b0, viol}, 32'd1);
        step;
        RSTN = 1'b0;
        #1;
        chk("viol_reset", {31'b0, viol}, 32'd0);
        step; RSTN = 1'b1;
        step; step; step;

        // Reset one cycle after a read grant drops the read
        step;
        d_req = 1'b1; d_addr = 32'h20; d_we = 4'b0;
        mid;
        chk("mid_rd_gnt", {31'b0, d_gnt}, 32'd1);
        step;
        d_req = 1'b0;
        RSTN = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        step; step;
        RSTN = 1'b1;
        repeat (8) step;

        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
